// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin arbiter sharing one binary-to-Gray converter.
// Ports: clk, rst_n, req, bin_in in; gnt, out_valid/gray/bin/id, conv_count out; out_ready in.
module gray_conv_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int CNT_W = 16,
  localparam int IDW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ*W-1:0] bin_in,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_gray,
  output logic [W-1:0]     out_bin,
  output logic [IDW-1:0]   out_id,
  output logic [CNT_W-1:0] conv_count
);

  typedef enum logic {EMPTY, FULL} st_e;

  st_e              state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [W-1:0]     gray_q, gray_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             slot_free;
  logic             grant;
  logic [IDW-1:0]   gnt_idx;
  logic [W-1:0]     sel_bin;
  logic [IDW:0]     sum;

  assign slot_free = !out_valid || out_ready;

  // Scan from ptr upward, wrapping at N_REQ; first active req wins.
  // rst_n gating keeps gnt low while reset is held.
  always_comb begin
    gnt     = '0;
    grant   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    if (rst_n && slot_free) begin
      for (int o = 0; o < N_REQ; o++) begin
        sum = {1'b0, ptr_q} + (IDW+1)'(o);
        if (sum >= (IDW+1)'(N_REQ))
          sum = sum - (IDW+1)'(N_REQ);
        if (!grant && req[sum[IDW-1:0]]) begin
          grant   = 1'b1;
          gnt_idx = sum[IDW-1:0];
        end
      end
      if (grant)
        gnt[gnt_idx] = 1'b1;
    end
  end

  assign sel_bin = bin_in[int'(gnt_idx)*W +: W];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      gray_q  <= '0;
      bin_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      EMPTY: if (grant) state_d = FULL;
      FULL:  if (out_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (grant) begin
      bin_d  = sel_bin;
      gray_d = sel_bin ^ (sel_bin >> 1);
      id_d   = gnt_idx;
      cnt_d  = cnt_q + CNT_W'(1);
      if (gnt_idx == IDW'(N_REQ - 1))
        ptr_d = '0;
      else
        ptr_d = gnt_idx + IDW'(1);
    end
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == FULL);
  end

  assign out_gray   = gray_q;
  assign out_bin    = bin_q;
  assign out_id     = id_q;
  assign conv_count = cnt_q;

endmodule
